sll_seq: RTL and testbench



---
 rtl/sll_seq_pkg.sv | 26 ++
 rtl/sll_seq_mux.sv | 18 +
 rtl/sll_seq.sv | 127 ++++++++++++
 tb/tb_sll_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sll_seq_pkg.sv
// Shared sequential-ALU package.
// Provides the 2-bit FSM state encoding used by the multi-cycle ALU units
// and a clog2 helper used to derive stage counts from data widths.
package sll_seq_pkg;

    // FSM state encoding shared by the sequential ALU units
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Ceiling log2. Returns 0 for values of 0 or 1.
    function automatic int clog2_f(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sll_seq_mux.sv
// Parameterised N-bit 2:1 multiplexer.
// Ports:
//   X   - data selected when S = 0
//   Y   - data selected when S = 1
//   S   - select
//   Z   - selected data
module param_2_to_1_mux #(
    parameter int N = 32
) (
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         S,
    output logic [N-1:0] Z
);

    assign Z = S ? Y : X;

endmodule

// File: rtl/sll_seq.sv
// Sequential shift-left-logical unit.
// Shifts X left by Y places with zero fill, applying one power-of-two stage
// per clock (largest stage first), behind a start/done handshake.
// Ports:
//   clk    - rising-edge clock
//   rstb   - asynchronous active-low reset
//   start  - request, sampled only while idle
//   X      - operand, captured on an accepted start
//   Y      - shift amount, captured on an accepted start
//   busy   - high whenever the unit is not idle
//   done   - one-cycle pulse marking a new result on Z
//   Z      - result register, held until the next done
module sll_seq
    import sll_seq_pkg::*;
#(
    parameter int N  = 32,
    parameter int SW = clog2_f(N)
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         start,
    input  logic [N-1:0] X,
    input  logic [31:0]  Y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Z
);

    localparam logic [SW-1:0] K_ONE  = SW'(1);
    localparam logic [SW-1:0] K_LAST = SW'(SW - 1);

    state_t        state_r;
    logic [N-1:0]  acc_r;
    logic [SW-1:0] amt_r;
    logic [SW-1:0] k_r;
    logic          busy_r;
    logic          done_r;
    logic [N-1:0]  z_r;

    logic [N-1:0]  shifted_s;
    logic          sel_s;
    logic [N-1:0]  stage_s;

    // Select the 2^k shifted accumulator and the matching amount bit for the current stage
    always_comb begin
        shifted_s = '0;
        sel_s     = 1'b0;
        for (int i = 0; i < SW; i++) begin
            if (k_r == SW'(i)) begin
                shifted_s = acc_r << (1 << i);
                sel_s     = amt_r[i];
            end else begin
                shifted_s = shifted_s;
                sel_s     = sel_s;
            end
        end
    end

    param_2_to_1_mux #(.N(N)) u_stage_mux (
        .X (acc_r),
        .Y (shifted_s),
        .S (sel_s),
        .Z (stage_s)
    );

    // Control FSM, accumulator and registered outputs
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r <= ST_IDLE;
            acc_r   <= '0;
            amt_r   <= '0;
            k_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            z_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        busy_r <= 1'b1;
                        amt_r  <= Y[SW-1:0];
                        k_r    <= K_LAST;
                        // Any high-order amount bit means a shift of N or more: result is zero.
                        if (|Y[31:SW]) begin
                            acc_r   <= '0;
                            z_r     <= '0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            acc_r   <= X;
                            state_r <= ST_SHIFT;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    acc_r <= stage_s;
                    if (k_r == '0) begin
                        // Z only ever sees the finished value.
                        z_r     <= stage_s;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        k_r <= k_r - K_ONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign Z    = z_r;

endmodule

// File: tb/tb_sll_seq.sv
module tb_sll_seq;

    logic        clk;
    logic        rstb;
    logic        start;
    logic [31:0] X;
    logic [31:0] Y;
    logic        busy;
    logic        done;
    logic [31:0] Z;

    int tests;
    int fails;

    sll_seq #(.N(32), .SW(5)) dut (
        .clk   (clk),
        .rstb  (rstb),
        .start (start),
        .X     (X),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp_z;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_sll(input logic [31:0] x, input logic [31:0] y);
        if (y >= 32'd32) return 32'd0;
        return x << y;
    endfunction

    // Issue one operation from an idle unit; return the result and the
    // number of cycles from the accepting edge until done was seen.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] z, output int lat);
        @(negedge clk);
        X = x;
        Y = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        X = $urandom;
        Y = $urandom;
        lat = 1;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        z = Z;
        @(negedge clk);
        check("done_pulse_width", {31'd0, done}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("z_held_after_done", Z, z);
    endtask

    initial begin
        logic [31:0] z;
        int          lat;
        logic [31:0] hx[35];
        logic [31:0] hy[35];
        logic [31:0] exp_z;

        tests = 0;
        fails = 0;
        rstb  = 1'b0;
        start = 1'b0;
        X     = 32'd0;
        Y     = 32'd0;

        vecs[0] = '{32'h0000_0001, 32'd31,         32'h8000_0000, 6};
        vecs[1] = '{32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 6};
        vecs[2] = '{32'h1234_5678, 32'd4,          32'h2345_6780, 6};
        vecs[3] = '{32'hFFFF_FFFF, 32'd32,         32'h0000_0000, 1};
        vecs[4] = '{32'h1234_5678, 32'h0000_0104,  32'h0000_0000, 1};
        vecs[5] = '{32'hA5A5_A5A5, 32'd1,          32'h4B4B_4B4A, 6};

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_z", Z, 32'd0);
        rstb = 1'b1;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].x, vecs[i].y, z, lat);
            check("vec_z", z, vecs[i].exp_z);
            check("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Reset in the middle of an operation
        @(negedge clk);
        X = 32'd1;
        Y = 32'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        check("midrst_z", Z, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        do_op(32'd3, 32'd2, z, lat);
        check("post_rst_z", z, 32'h0000_000C);
        check("post_rst_latency", 32'(lat), 32'd6);

        // Start held high with operands changing every cycle
        exp_z = z;
        @(negedge clk);
        for (int j = 0; j < 35; j++) begin
            hx[j] = $urandom;
            hy[j] = 32'($urandom_range(0, 31));
        end
        X = hx[0];
        Y = hy[0];
        start = 1'b1;
        for (int j = 1; j < 35; j++) begin
            @(negedge clk);
            if ((j % 7) == 6) begin
                exp_z = ref_sll(hx[j - 6], hy[j - 6]);
                check("hold_done", {31'd0, done}, 32'd1);
            end else begin
                check("hold_no_done", {31'd0, done}, 32'd0);
            end
            check("hold_z", Z, exp_z);
            X = hx[j];
            Y = hy[j];
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized regression
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] rx;
            logic [31:0] ry;
            int          pick;
            rx   = $urandom;
            pick = $urandom_range(0, 9);
            if (pick == 0) ry = $urandom;
            else if (pick == 1) ry = 32'($urandom_range(32, 63));
            else ry = 32'($urandom_range(0, 31));
            do_op(rx, ry, z, lat);
            check("rand_z", z, ref_sll(rx, ry));
            check("rand_latency", 32'(lat), (ry >= 32'd32) ? 32'd1 : 32'd6);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
